// File: rtl/regfile_dump_pkg.sv
// regfile_dump_pkg: shared types and defaults for the register-file dump engine.
// Provides ADDR_W/DATA_W defaults, the register count and the FSM state enum.
package regfile_dump_pkg;

    localparam int NREGS      = 32;
    localparam int ADDR_W_DEF = $clog2(NREGS);
    localparam int DATA_W_DEF = 32;

    // CSUM keeps its encoding even when the checksum beat is compiled out.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SEND  = 3'd2,
        CSUM  = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/regfile_dump_csum.sv
// regfile_dump_csum: XOR accumulator over the emitted register values.
// Ports: clk, resetn (sync, active low), clr (zero the sum), en (fold in din),
//        din (beat value), acc (current sum), acc_nxt (acc ^ din, combinational).
module regfile_dump_csum
    import regfile_dump_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] acc,
    output logic [DATA_W-1:0] acc_nxt
);

    assign acc_nxt = acc ^ din;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_nxt;
        end
    end

endmodule

// File: rtl/regfile_dump.sv
// regfile_dump: streams a contiguous (optionally wrapping) register range
// out of a register-file read port as value/index beats on valid/ready.
// Ports: clk, resetn (sync, active low); start/first_addr/last_addr request;
//        rf_rs/rf_rv register-file read port; out_valid/out_ready/out_data/
//        out_addr/out_last beat stream; busy, done status.
// Build option: define REGFILE_DUMP_CSUM_EN to append an XOR checksum beat.
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rf_rs,
    input  logic [DATA_W-1:0] rf_rv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] end_addr;
    logic              hs;
    logic              at_end;

    assign hs     = out_valid & out_ready;
    assign at_end = (ptr == end_addr);

`ifdef REGFILE_DUMP_CSUM_EN
    logic [DATA_W-1:0] csum_acc;
    logic [DATA_W-1:0] csum_nxt;

    regfile_dump_csum #(
        .DATA_W (DATA_W)
    ) u_csum (
        .clk     (clk),
        .resetn  (resetn),
        .clr     ((state == IDLE) && start),
        .en      ((state == SEND) && hs),
        .din     (out_data),
        .acc     (csum_acc),
        .acc_nxt (csum_nxt)
    );

    localparam state_t AFTER_LAST = CSUM;
`else
    localparam state_t AFTER_LAST = DONE;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (start) state_nxt = FETCH;
            FETCH: state_nxt = SEND;
            SEND:  if (hs) state_nxt = at_end ? AFTER_LAST : FETCH;
            CSUM:  if (hs) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address is only driven while fetching; zero otherwise.
    assign rf_rs     = (state == FETCH) ? ptr : '0;
    assign out_valid = (state == SEND) || (state == CSUM);
    assign busy      = (state == FETCH) || (state == SEND) ||
                       (state == CSUM);
    assign done      = (state == DONE);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            ptr      <= '0;
            end_addr <= '0;
            out_data <= '0;
            out_addr <= '0;
            out_last <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        ptr      <= first_addr;
                        end_addr <= last_addr;
                    end
                end
                FETCH: begin
                    out_data <= rf_rv;
                    out_addr <= ptr;
`ifdef REGFILE_DUMP_CSUM_EN
                    out_last <= 1'b0;
`else
                    out_last <= at_end;
`endif
                end
                SEND: begin
                    // Pointer wraps naturally at 2^ADDR_W.
                    if (hs && !at_end) begin
                        ptr <= ptr + 1'b1;
                    end
`ifdef REGFILE_DUMP_CSUM_EN
                    // Sum must include the beat handshaking right now.
                    if (hs && at_end) begin
                        out_data <= csum_nxt;
                        out_addr <= '0;
                        out_last <= 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: randomized scoreboard bench for regfile_dump.
// Honours REGFILE_DUMP_CSUM_EN in its reference model.
module tb_regfile_dump;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  first_addr = '0;
    logic [4:0]  last_addr = '0;
    logic [4:0]  rf_rs;
    logic [31:0] rf_rv;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [4:0]  out_addr;
    logic        out_last;
    logic        busy;
    logic        done;

    regfile_dump dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .rf_rs      (rf_rs),
        .rf_rv      (rf_rv),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Register file model with synchronous write, combinational read.
    logic [31:0] rf [32];
    logic        ld = 1'b1;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_idx = '0;
    logic [31:0] wr_val = '0;

    always @(posedge clk) begin
        if (ld) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'(i) * 32'h1111_1111;
        end else if (wr_en) begin
            rf[wr_idx] <= wr_val;
        end
    end

    assign rf_rv = rf[rf_rs];

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic        l;
    } beat_t;

    beat_t q[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected beats straight from the range rule and the model's contents.
    task automatic push_exp(int f, int l);
        int    n;
        int    a;
        beat_t b;
        logic [31:0] sum;
        n = ((l - f + 32) % 32) + 1;
        sum = '0;
        for (int k = 0; k < n; k++) begin
            a = (f + k) % 32;
            b.a = 5'(a);
            b.d = rf[a];
            sum = sum ^ rf[a];
`ifdef REGFILE_DUMP_CSUM_EN
            b.l = 1'b0;
`else
            b.l = (k == n - 1);
`endif
            q.push_back(b);
        end
`ifdef REGFILE_DUMP_CSUM_EN
        b.a = '0;
        b.d = sum;
        b.l = 1'b1;
        q.push_back(b);
`endif
    endtask

    // Monitor: every presented beat must match the queue head; pop on accept.
    always @(negedge clk) begin
        if (resetn && out_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat_unexpected: got addr %0d data %h, expected none",
                         out_addr, out_data);
            end else begin
                chk("beat", 64'({out_addr, out_data, out_last}), 64'(q[0]));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic start_dump(int f, int l);
        @(posedge clk); #1;
        push_exp(f, l);
        start = 1'b1;
        first_addr = 5'(f);
        last_addr = 5'(l);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(int budget, bit rnd);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk); #1;
                if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            end
        end
        chk("done_seen", 64'(seen), 64'd1);
        if (seen) begin
            chk("busy_at_done", 64'(busy), 64'd0);
            chk("queue_empty_at_done", 64'(q.size()), 64'd0);
            @(negedge clk);
            chk("done_one_cycle", 64'(done), 64'd0);
        end else begin
            q.delete();
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int f;
        int l;

        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        ld = 1'b0;
        @(negedge clk);
        chk("reset_outputs",
            64'({out_valid, out_data, out_addr, out_last, busy, done, rf_rs}),
            64'd0);

        // Basic 3..5 dump with latency checks.
        out_ready = 1'b1;
        start_dump(3, 5);
        @(negedge clk);
        chk("latency_fetch_valid", 64'(out_valid), 64'd0);
        chk("fetch_rf_rs", 64'(rf_rs), 64'd3);
        chk("busy_after_start", 64'(busy), 64'd1);
        @(negedge clk);
        chk("latency_send_valid", 64'(out_valid), 64'd1);
        wait_done(50, 1'b0);

        // Wrapping range.
        start_dump(30, 1);
        wait_done(50, 1'b0);

        // Stall on the second beat plus an ignored mid-burst start.
        out_ready = 1'b0;
        start_dump(3, 5);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #1;
            if (out_valid) found = 1'b1;
        end
        chk("stall_first_valid", 64'(found), 64'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            start = (k == 3);
            first_addr = 5'd10;
            last_addr = 5'd12;
        end
        start = 1'b0;
        out_ready = 1'b1;
        wait_done(50, 1'b0);

        // Write at the FETCH edge of x4 is not seen; later dump sees it.
        start_dump(3, 5);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (rf_rs == 5'd4) found = 1'b1;
        end
        chk("coherency_fetch4", 64'(found), 64'd1);
        wr_en = 1'b1;
        wr_idx = 5'd4;
        wr_val = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        wr_en = 1'b0;
        wait_done(50, 1'b0);
        start_dump(4, 4);
        wait_done(50, 1'b0);

        // Random ranges with random backpressure.
        for (int r = 0; r < 12; r++) begin
            f = int'($urandom_range(0, 31));
            l = int'($urandom_range(0, 31));
            start_dump(f, l);
            wait_done(800, 1'b1);
        end

        // Reset in SEND of a full dump.
        start_dump(0, 31);
        repeat (4) @(posedge clk);
        #1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (out_valid) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("reset_in_send", 64'(found), 64'd1);
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        q.delete();
        @(negedge clk);
        chk("midburst_reset_outputs",
            64'({out_valid, out_data, out_addr, out_last, busy, done, rf_rs}),
            64'd0);
        start_dump(7, 7);
        wait_done(50, 1'b0);

`ifdef REGFILE_DUMP_CSUM_EN
        @(posedge clk); #1;
        wr_en = 1'b1;
        wr_idx = 5'd1;
        wr_val = 32'h0F0F_0F0F;
        @(posedge clk); #1;
        wr_idx = 5'd2;
        wr_val = 32'h00FF_00FF;
        @(posedge clk); #1;
        wr_en = 1'b0;
        start_dump(1, 2);
        wait_done(50, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Debug read-out engine: the reader end of the register-file read port.
- Drives a register-file read address, samples the combinational read data, and streams each register value with its index over a valid/ready handshake.
- Sits beside the CPU register file on the second read port (or a debug mux on it), feeding a trace/UART/testbench sink.
- One burst dumps a contiguous, optionally wrapping, range of registers.

Parameters:
- ADDR_W, 5, register index width (32 registers)
- DATA_W, 32, register value width

Ports:
- clk  in  1  clock; all state changes at posedge
- resetn  in  1  synchronous active-low reset
- start  in  1  single-cycle request to begin a dump; sampled only in IDLE
- first_addr  in  ADDR_W  first register index of the range; sampled with start
- last_addr  in  ADDR_W  last register index of the range; sampled with start
- rf_rs  out  ADDR_W  read address to the register file
- rf_rv  in  DATA_W  combinational read data from the register file
- out_valid  out  1  beat valid
- out_ready  in  1  sink accepts beat
- out_data  out  DATA_W  register value
- out_addr  out  ADDR_W  register index of the beat
- out_last  out  1  final beat of the burst
- busy  out  1  high from the cycle after start acceptance until DONE
- done  out  1  one-cycle pulse at the end of the burst

Behaviour:
- Reset: resetn sampled low at posedge forces IDLE from any state, including mid-burst. All outputs are 0 the following cycle: out_valid, out_data, out_addr, out_last, busy, done, rf_rs. An in-flight beat is dropped.
- State IDLE: rf_rs=0, busy=0.
  - start=1 latches ptr=first_addr and end=last_addr, then goes to FETCH.
- State FETCH (1 cycle): rf_rs=ptr.
  - Registers out_data<=rf_rv, out_addr<=ptr, out_last<=(ptr==end) (with checksum disabled).
  - Sets out_valid=1 and goes to SEND.
- State SEND: out_valid=1. out_data, out_addr and out_last are held stable until handshake (out_valid & out_ready at posedge).
  - Handshake with ptr!=end: ptr<=ptr+1 modulo 2^ADDR_W, out_valid<=0, go to FETCH.
  - Handshake with ptr==end: out_valid<=0, go to DONE (or CSUM when the feature is enabled).
  - out_ready low stalls indefinitely with no beat loss.
- State DONE: done=1 for exactly one cycle, busy=0, return to IDLE.
- Throughput: at most one beat per 2 cycles. Latency from start to first out_valid is 2 cycles.
- Range rules:
  - first==last gives 1 beat.
  - first<last gives last-first+1 beats.
  - first>last wraps through 31 to 0, giving (last-first+1) mod 32 beats; a full 32 beats when last==first-1.
- start while not IDLE is ignored. A start in the same cycle as DONE is ignored.
- Coherency:
  - Value is sampled in FETCH. A register-file write to the same index at the FETCH posedge is not seen; the old value is emitted.
  - Writes after FETCH do not alter the pending beat.
- out_valid never deasserts without handshake except on reset.

Optional Feature:
- Macro REGFILE_DUMP_CSUM_EN.
- Defined:
  - An XOR accumulator clears on start acceptance and XORs in each beat's out_data at handshake.
  - After the handshake with ptr==end, state CSUM presents one extra beat: out_data=accumulator, out_addr=0, out_last=1, same stall rules. Its handshake goes to DONE.
  - Register beats then all have out_last=0.
- Undefined:
  - No accumulator and no CSUM state.
  - out_last=1 on the final register beat.

Decomposition:
- Package regfile_dump_pkg:
  - ADDR_W/DATA_W defaults.
  - State enum IDLE, FETCH, SEND, CSUM, DONE (CSUM encoding reserved even when the feature is off).
  - NREGS=32 constant.
- Sub-module regfile_dump_csum (XOR accumulator with clear/enable), instantiated only under REGFILE_DUMP_CSUM_EN. FSM and range counter stay in the top.

Test Plan:
- Regfile preloaded x[i]=i*0x11111111 mod 2^32, start with first=3, last=5, out_ready=1 -> beats (3,0x33333333),(5,0x55555555) around (4,0x44444444) in order 3,4,5; out_last only on addr 5; done pulse; first out_valid 2 cycles after start.
- first=30, last=1 -> 4 beats with addrs 30,31,0,1; x0 value 0; out_last on addr 1.
- Same as first, with out_ready low for 5 cycles on the second beat -> out_data/out_addr stable during stall, no duplicate or missing beat; a start pulse mid-burst is ignored.
- Regfile write of 0xDEADBEEF to x4 at the FETCH posedge for addr 4 -> emitted value 0x44444444; a later dump emits 0xDEADBEEF.
- resetn low in SEND of a 0..31 dump -> next cycle all outputs 0, state IDLE; a new start with first=last=7 yields a single beat with out_last=1.
- REGFILE_DUMP_CSUM_EN defined, first=1, last=2, x1=0x0F0F0F0F, x2=0x00FF00FF -> two beats with out_last=0, then beat (addr 0, 0x0FF00FF0, out_last=1), then done.
